// File: rtl/ad7606_par_rd_if.sv
// AD7606 parallel-interface pin bundle.
//   master : the read controller (drives RESET/CONVST/CS_N/RD_N, reads BUSY/DB)
//   slave  : the converter side (drives BUSY/DB)
// Signals:
//   ad_busy   BUSY from the converter, asynchronous to the controller clock
//   ad_db     16-bit parallel data bus
//   ad_reset  converter RESET, active-high
//   ad_convst CONVST A/B tied, conversion starts on rising edge
//   ad_cs_n   chip select, active-low
//   ad_rd_n   read strobe, active-low
interface ad7606_par_rd_if;
  logic        ad_busy;
  logic [15:0] ad_db;
  logic        ad_reset;
  logic        ad_convst;
  logic        ad_cs_n;
  logic        ad_rd_n;

  modport master (
    input  ad_busy,
    input  ad_db,
    output ad_reset,
    output ad_convst,
    output ad_cs_n,
    output ad_rd_n
  );

  modport slave (
    output ad_busy,
    output ad_db,
    input  ad_reset,
    input  ad_convst,
    input  ad_cs_n,
    input  ad_rd_n
  );
endinterface

// File: rtl/ad7606_par_rd.sv
// AD7606 parallel read controller.
// Pulses the converter reset after rst, then on each start request runs one
// frame: CONVST low pulse, wait for BUSY high then low, and a CS_N/RD_N burst
// reading CH_NUM channels. Each raw sample leaves on data_out with its channel
// index and a one-cycle data_valid strobe; samples are passed through untouched.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   start        one-cycle frame request, honoured only in IDLE
//   ad           AD7606 pin bundle (master side)
//   data_out     captured 16-bit sample (two's complement, unmodified)
//   data_ch      channel index of data_out
//   data_valid   one-cycle strobe, data_out/data_ch valid
//   frame_done   one-cycle strobe the cycle after the last sample of a frame
//   busy         high whenever the FSM is not in IDLE
//   timeout_err  one-cycle strobe when a BUSY edge does not arrive in time
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ADRST    | converter RESET held high for RST_CYC cycles after rst
// IDLE     | waiting for start
// CONV     | CONVST held low for CONV_LOW_CYC cycles
// WAIT_BH  | waiting for synchronized BUSY to rise (bounded by BUSY_TO_CYC)
// WAIT_BL  | waiting for synchronized BUSY to fall (bounded by BUSY_TO_CYC)
// RD_LO    | CS_N/RD_N low for RD_LOW_CYC cycles, data latched on last cycle
// RD_HI    | CS_N low, RD_N high for RD_HIGH_CYC cycles between channels
// DONE     | CS_N released, frame_done follows
module ad7606_par_rd #(
  parameter int RST_CYC      = 5,
  parameter int CONV_LOW_CYC = 2,
  parameter int RD_LOW_CYC   = 3,
  parameter int RD_HIGH_CYC  = 2,
  parameter int CH_NUM       = 8,
  parameter int BUSY_TO_CYC  = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  ad7606_par_rd_if.master        ad,
  output logic [15:0]            data_out,
  output logic [2:0]             data_ch,
  output logic                   data_valid,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int PH_A   = (RST_CYC > CONV_LOW_CYC) ? RST_CYC : CONV_LOW_CYC;
  localparam int PH_B   = (RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC;
  localparam int PH_MAX = (PH_A > PH_B) ? PH_A : PH_B;
  localparam int TW     = $clog2(PH_MAX + 1);
  localparam int WW     = $clog2(BUSY_TO_CYC + 1);
  localparam int CW     = $clog2(CH_NUM + 1);

  typedef enum logic [2:0] {
    ST_ADRST,
    ST_IDLE,
    ST_CONV,
    ST_WAIT_BH,
    ST_WAIT_BL,
    ST_RD_LO,
    ST_RD_HI,
    ST_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic [WW-1:0]   wait_tmr, wait_nxt;
  logic [CW-1:0]   ch_cnt, ch_nxt;
  logic            busy_meta, busy_s;
  logic            capture;
  logic            done_nxt;
  logic            to_nxt;

  // Phase timers are down-counters loaded with (length - 1); the phase ends
  // on the cycle the counter reads zero, so a phase lasts exactly length cycles.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    wait_nxt  = wait_tmr;
    ch_nxt    = ch_cnt;
    capture   = 1'b0;
    done_nxt  = 1'b0;
    to_nxt    = 1'b0;
    busy      = (state != ST_IDLE);

    case (state)
      ST_ADRST: begin
        if (tmr == '0) state_nxt = ST_IDLE;
        else           tmr_nxt   = tmr - TW'(1);
      end

      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_CONV;
          tmr_nxt   = TW'(CONV_LOW_CYC - 1);
        end
      end

      ST_CONV: begin
        if (tmr == '0) begin
          state_nxt = ST_WAIT_BH;
          wait_nxt  = WW'(BUSY_TO_CYC - 1);
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end

      ST_WAIT_BH: begin
        if (busy_s) begin
          state_nxt = ST_WAIT_BL;
          wait_nxt  = WW'(BUSY_TO_CYC - 1);
        end else if (wait_tmr == '0) begin
          state_nxt = ST_IDLE;
          to_nxt    = 1'b1;
        end else begin
          wait_nxt = wait_tmr - WW'(1);
        end
      end

      ST_WAIT_BL: begin
        if (!busy_s) begin
          state_nxt = ST_RD_LO;
          tmr_nxt   = TW'(RD_LOW_CYC - 1);
          ch_nxt    = '0;
        end else if (wait_tmr == '0) begin
          state_nxt = ST_IDLE;
          to_nxt    = 1'b1;
        end else begin
          wait_nxt = wait_tmr - WW'(1);
        end
      end

      ST_RD_LO: begin
        if (tmr == '0) begin
          capture = 1'b1;
          // Last channel skips the trailing RD_HI and releases CS_N directly.
          if (ch_cnt == CW'(CH_NUM - 1)) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_RD_HI;
            tmr_nxt   = TW'(RD_HIGH_CYC - 1);
            ch_nxt    = ch_cnt + CW'(1);
          end
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end

      ST_RD_HI: begin
        if (tmr == '0) begin
          state_nxt = ST_RD_LO;
          tmr_nxt   = TW'(RD_LOW_CYC - 1);
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end

      default: begin
        state_nxt = ST_ADRST;
        tmr_nxt   = TW'(RST_CYC - 1);
      end
    endcase
  end

  // Converter pins are registered from the next state so they change cleanly
  // on the clock edge with no decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_ADRST;
      tmr          <= TW'(RST_CYC - 1);
      wait_tmr     <= '0;
      ch_cnt       <= '0;
      busy_meta    <= 1'b0;
      busy_s       <= 1'b0;
      ad.ad_reset  <= 1'b1;
      ad.ad_convst <= 1'b1;
      ad.ad_cs_n   <= 1'b1;
      ad.ad_rd_n   <= 1'b1;
      data_out     <= '0;
      data_ch      <= '0;
      data_valid   <= 1'b0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      tmr          <= tmr_nxt;
      wait_tmr     <= wait_nxt;
      ch_cnt       <= ch_nxt;
      busy_meta    <= ad.ad_busy;
      busy_s       <= busy_meta;
      ad.ad_reset  <= (state_nxt == ST_ADRST);
      ad.ad_convst <= (state_nxt != ST_CONV);
      ad.ad_cs_n   <= !((state_nxt == ST_RD_LO) || (state_nxt == ST_RD_HI));
      ad.ad_rd_n   <= (state_nxt != ST_RD_LO);
      if (capture) begin
        data_out <= ad.ad_db;
        data_ch  <= 3'(ch_cnt);
      end
      data_valid   <= capture;
      frame_done   <= done_nxt;
      timeout_err  <= to_nxt;
    end
  end

endmodule

// File: tb/tb_ad7606_par_rd.sv
// Bench for ad7606_par_rd: behavioural AD7606 model plus an output monitor,
// with per-frame expectations computed from the sample table and the
// configured cycle counts.
module tb_ad7606_par_rd;
  localparam int RST_CYC      = 5;
  localparam int CONV_LOW_CYC = 2;
  localparam int RD_LOW_CYC   = 3;
  localparam int RD_HIGH_CYC  = 2;
  localparam int CH_NUM       = 8;
  localparam int BUSY_TO_CYC  = 1000;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_out;
  logic [2:0]  data_ch;
  logic        data_valid;
  logic        frame_done;
  logic        busy;
  logic        timeout_err;

  ad7606_par_rd_if ad();

  ad7606_par_rd #(
    .RST_CYC     (RST_CYC),
    .CONV_LOW_CYC(CONV_LOW_CYC),
    .RD_LOW_CYC  (RD_LOW_CYC),
    .RD_HIGH_CYC (RD_HIGH_CYC),
    .CH_NUM      (CH_NUM),
    .BUSY_TO_CYC (BUSY_TO_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ad         (ad),
    .data_out   (data_out),
    .data_ch    (data_ch),
    .data_valid (data_valid),
    .frame_done (frame_done),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          cyc;
    logic [15:0] d;
    logic [2:0]  ch;
    int          lo;
    logic        cs_n;
  } vrec_t;

  vrec_t       vq[$];
  int          fd_q[$];
  int          to_q[$];
  int          cv_q[$];
  logic        to_busy_q[$];
  logic [15:0] samples [CH_NUM];

  int   n_chk     = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   cs_low    = 0;
  int   last_cv   = 0;
  int   last_fall = -1;
  int   last_lo   = 0;
  int   lo_run    = 0;
  int   cv_run    = 0;
  int   rise_at   = -1;
  int   fall_at   = -1;
  int   rd_idx    = 0;
  int   busy_dly  = 2;
  int   busy_len  = 200;
  bit   busy_en   = 1'b1;
  logic cv_prev   = 1'b1;
  logic rd_prev   = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", tag, obs, exp);
    end
  endtask

  // Converter model and output monitor, both evaluated mid-cycle.
  initial begin : adc_and_monitor
    vrec_t r;
    ad.ad_busy = 1'b0;
    ad.ad_db   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (ad.ad_rd_n === 1'b0) lo_run++;
      else if (lo_run != 0) begin
        last_lo = lo_run;
        lo_run  = 0;
      end
      if (ad.ad_convst === 1'b0) cv_run++;
      else if (cv_run != 0) begin
        last_cv = cv_run;
        cv_run  = 0;
        cv_q.push_back(cyc);
      end
      if (ad.ad_cs_n === 1'b0) cs_low++;
      if (data_valid === 1'b1) begin
        r.cyc  = cyc;
        r.d    = data_out;
        r.ch   = data_ch;
        r.lo   = last_lo;
        r.cs_n = ad.ad_cs_n;
        vq.push_back(r);
      end
      if (frame_done === 1'b1) fd_q.push_back(cyc);
      if (timeout_err === 1'b1) begin
        to_q.push_back(cyc);
        to_busy_q.push_back(busy);
      end

      if (cv_prev === 1'b0 && ad.ad_convst === 1'b1) begin
        rd_idx = 0;
        if (busy_en) begin
          rise_at = cyc + busy_dly;
          fall_at = rise_at + busy_len;
        end
      end
      if (cyc == rise_at) ad.ad_busy = 1'b1;
      if (cyc == fall_at) begin
        ad.ad_busy = 1'b0;
        last_fall  = cyc;
      end
      if (rd_prev === 1'b1 && ad.ad_rd_n === 1'b0) begin
        ad.ad_db = samples[rd_idx % CH_NUM];
        rd_idx++;
      end
      cv_prev = ad.ad_convst;
      rd_prev = ad.ad_rd_n;
    end
  end

  task automatic reset_release(input string tag);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b1;
    while (ad.ad_reset === 1'b1 && n < 50) begin
      if (ad.ad_cs_n !== 1'b1 || ad.ad_rd_n !== 1'b1 || ad.ad_convst !== 1'b1 || busy !== 1'b1)
        ok = 1'b0;
      n++;
      @(negedge clk);
    end
    chk({tag, "_reset_len"}, n, RST_CYC);
    chk({tag, "_strobes_idle"}, 32'(ok), 1);
    chk({tag, "_busy_low"}, 32'(busy), 0);
  endtask

  task automatic run_frame(input bit expect_to, input bit extra_start, input int gap);
    int v0, f0, t0, c0, n;
    bit sent;
    v0 = vq.size();
    f0 = fd_q.size();
    t0 = to_q.size();
    c0 = cv_q.size();
    cs_low = 0;
    sent   = 1'b0;
    n      = 0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    while (fd_q.size() == f0 && to_q.size() == t0 && n < 3000) begin
      if (extra_start && !sent && vq.size() >= v0 + 2) begin
        start = 1'b1;
        sent  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("frame_end_bound", 32'(n < 3000), 1);
    repeat (gap) @(negedge clk);
    chk("convst_pulses", cv_q.size() - c0, 1);
    chk("convst_low_len", last_cv, CONV_LOW_CYC);
    if (expect_to) begin
      chk("to_count", to_q.size() - t0, 1);
      if (to_q.size() > t0 && cv_q.size() > c0) begin
        chk("to_latency", to_q[t0] - cv_q[c0], BUSY_TO_CYC);
        chk("to_idle", 32'(to_busy_q[t0]), 0);
      end
      chk("to_no_valid", vq.size() - v0, 0);
      chk("to_no_done", fd_q.size() - f0, 0);
      chk("to_cs_idle", cs_low, 0);
    end else begin
      chk("valid_count", vq.size() - v0, CH_NUM);
      chk("done_count", fd_q.size() - f0, 1);
      chk("no_timeout", to_q.size() - t0, 0);
      chk("cs_low_len", cs_low, CH_NUM * RD_LOW_CYC + (CH_NUM - 1) * RD_HIGH_CYC);
      if (vq.size() - v0 == CH_NUM && fd_q.size() > f0) begin
        // BUSY fall: two synchronizer stages, one decision edge, then RD_LO.
        chk("first_valid_lat", vq[v0].cyc - last_fall, 3 + RD_LOW_CYC);
        for (int k = 0; k < CH_NUM; k++) begin
          chk("data", 32'(vq[v0 + k].d), 32'(samples[k]));
          chk("ch", 32'(vq[v0 + k].ch), k);
          chk("rd_low_len", vq[v0 + k].lo, RD_LOW_CYC);
          chk("cs_n_at_valid", 32'(vq[v0 + k].cs_n), 32'(k == CH_NUM - 1));
          if (k > 0)
            chk("valid_gap", vq[v0 + k].cyc - vq[v0 + k - 1].cyc, RD_LOW_CYC + RD_HIGH_CYC);
        end
        chk("done_after_last", fd_q[f0] - vq[v0 + CH_NUM - 1].cyc, 1);
      end
    end
  endtask

  task automatic mid_frame_reset();
    int v0, f0, n;
    for (int k = 0; k < CH_NUM; k++) samples[k] = 16'($urandom);
    busy_dly = 2;
    busy_len = $urandom_range(3, 100);
    v0 = vq.size();
    f0 = fd_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (vq.size() < v0 + 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    while (ad.ad_rd_n !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach_ch3", 32'(n < 2000), 1);
    chk("mid_ch_before", vq.size() - v0, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_cs_n", 32'(ad.ad_cs_n), 1);
    chk("mid_rd_n", 32'(ad.ad_rd_n), 1);
    chk("mid_convst", 32'(ad.ad_convst), 1);
    chk("mid_ad_reset", 32'(ad.ad_reset), 1);
    chk("mid_valid", 32'(data_valid), 0);
    chk("mid_data_out", 32'(data_out), 0);
    rst = 1'b0;
    reset_release("mid");
    repeat (20) @(negedge clk);
    chk("mid_no_more_valid", vq.size() - v0, 3);
    chk("mid_no_done", fd_q.size() - f0, 0);
  endtask

  initial begin : main
    rst     = 1'b1;
    start   = 1'b0;
    busy_en = 1'b1;
    for (int k = 0; k < CH_NUM; k++) samples[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ad_reset", 32'(ad.ad_reset), 1);
    chk("rst_convst", 32'(ad.ad_convst), 1);
    chk("rst_cs_n", 32'(ad.ad_cs_n), 1);
    chk("rst_rd_n", 32'(ad.ad_rd_n), 1);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_data_ch", 32'(data_ch), 0);
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_busy", 32'(busy), 1);
    rst = 1'b0;
    reset_release("por");

    for (int k = 0; k < CH_NUM; k++) samples[k] = 16'(32'h1000 + k);
    busy_dly = 2;
    busy_len = 200;
    run_frame(1'b0, 1'b0, 10);

    samples[0] = 16'h8000;
    run_frame(1'b0, 1'b0, 10);

    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < CH_NUM; k++) samples[k] = 16'($urandom);
      busy_dly = $urandom_range(1, 5);
      busy_len = $urandom_range(3, 300);
      run_frame(1'b0, 1'b0, $urandom_range(2, 30));
    end

    for (int k = 0; k < CH_NUM; k++) samples[k] = 16'($urandom);
    run_frame(1'b0, 1'b1, 300);

    busy_en = 1'b0;
    run_frame(1'b1, 1'b0, 10);
    busy_en = 1'b1;

    mid_frame_reset();
    for (int k = 0; k < CH_NUM; k++) samples[k] = 16'($urandom);
    run_frame(1'b0, 1'b0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
